// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking gate controller.
// Latency: none (package only).
// Backpressure: none (package only).
package parking_pkg;

    localparam int CAR_ID_W  = 2;
    localparam int NUM_SLOTS = 4;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY_STB,
        ENTRY_OPEN,
        EXIT_STB,
        EXIT_OPEN
    } gate_state_t;

    // Lowest-numbered clear bit; returns 0 when every slot is taken, which the
    // caller never uses because a full lot is rejected before allocation.
    function automatic logic [CAR_ID_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] occ);
        logic [CAR_ID_W-1:0] id;
        id = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                id = CAR_ID_W'(i);
            end
        end
        return id;
    endfunction

    function automatic logic [CAR_ID_W:0] popcount(input logic [NUM_SLOTS-1:0] occ);
        logic [CAR_ID_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + {{CAR_ID_W{1'b0}}, occ[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Sensor front end: 2-flop synchroniser, optional debounce, rising-edge request.
// Latency: raw edge to req = 2 cycles (+DEBOUNCE_CYCLES with PARKING_GATE_DEBOUNCE_EN).
// Backpressure: none; req is a single-cycle pulse the consumer must latch.
// Ports: clk, reset (async, active-high), sensor_async (raw level), req (edge pulse).
// Macro: PARKING_GATE_DEBOUNCE_EN enables the stability filter after the synchroniser.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_async,
    output logic req
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_async;
            sync2_q <= sync1_q;
        end
    end

`ifdef PARKING_GATE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles where the synchronised input disagrees with the
    // filtered level; any agreement restarts the count, so short glitches vanish.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
`else
    logic unused_debounce_cycles;
    assign unused_debounce_cycles = (DEBOUNCE_CYCLES > 0);
    assign level = sync2_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign req = level & ~prev_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Gate-side controller: turns entry/exit sensor edges into core strobes, slot IDs and barrier drives.
// Latency: sensor edge -> pend 3 cycles (+DEBOUNCE_CYCLES with debounce), pend -> strobe 2 cycles.
// Backpressure: none; requests arriving while busy stay pending, repeat edges on a set pend are absorbed.
// Ports: clk, reset (async, active-high); entry_sensor, exit_sensor (raw levels), exit_ticket_id,
//        barrier_clear; entry/exit strobes with Car_Id, entry/exit_gate_open, occupied bitmap, reject.
// Macro: PARKING_GATE_DEBOUNCE_EN adds a DEBOUNCE_CYCLES stability filter on both sensors.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int MAX_CARS        = 3,
    parameter int GATE_TIMEOUT    = 32,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_sensor,
    input  logic                 exit_sensor,
    input  logic [CAR_ID_W-1:0]  exit_ticket_id,
    input  logic                 barrier_clear,
    output logic                 entry,
    output logic                 exit,
    output logic [CAR_ID_W-1:0]  Car_Id,
    output logic                 entry_gate_open,
    output logic                 exit_gate_open,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic                 reject
);

    localparam int TMR_W = $clog2(GATE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);
    localparam logic [CAR_ID_W:0]   MAX_CNT  = (CAR_ID_W + 1)'(MAX_CARS);

    logic entry_req;
    logic exit_req;

    gate_state_t          state_q,      state_d;
    logic [NUM_SLOTS-1:0] occ_q,        occ_d;
    logic [CAR_ID_W-1:0]  car_id_q,     car_id_d;
    logic [CAR_ID_W-1:0]  ticket_q,     ticket_d;
    logic [TMR_W-1:0]     timer_q,      timer_d;
    logic                 entry_pend_q, entry_pend_d;
    logic                 exit_pend_q,  exit_pend_d;
    logic                 reject_q,     reject_d;
    logic                 entry_clr;
    logic                 exit_clr;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_entry_sense (
        .clk          (clk),
        .reset        (reset),
        .sensor_async (entry_sensor),
        .req          (entry_req)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_exit_sense (
        .clk          (clk),
        .reset        (reset),
        .sensor_async (exit_sensor),
        .req          (exit_req)
    );

    // A request landing in the same cycle as its pend is consumed is a fresh
    // car, so it wins over the clear. The ticket is only re-latched when the
    // request is actually new, keeping an absorbed duplicate from corrupting it.
    always_comb begin
        entry_pend_d = (entry_pend_q & ~entry_clr) | entry_req;
        exit_pend_d  = (exit_pend_q  & ~exit_clr)  | exit_req;
        ticket_d     = ticket_q;
        if (exit_req && (!exit_pend_q || exit_clr)) begin
            ticket_d = exit_ticket_id;
        end
    end

    // Car_Id is chosen at the IDLE decision and registered into the STB cycle,
    // so it is valid with the strobe and naturally holds until the next one.
    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        car_id_d  = car_id_q;
        timer_d   = timer_q;
        reject_d  = 1'b0;
        entry_clr = 1'b0;
        exit_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (exit_pend_q) begin
                    if (occ_q[ticket_q]) begin
                        state_d  = EXIT_STB;
                        car_id_d = ticket_q;
                    end else begin
                        reject_d = 1'b1;
                        exit_clr = 1'b1;
                    end
                end else if (entry_pend_q) begin
                    if (popcount(occ_q) < MAX_CNT) begin
                        state_d  = ENTRY_STB;
                        car_id_d = lowest_free(occ_q);
                    end else begin
                        reject_d  = 1'b1;
                        entry_clr = 1'b1;
                    end
                end
            end
            ENTRY_STB: begin
                occ_d[car_id_q] = 1'b1;
                entry_clr       = 1'b1;
                timer_d         = '0;
                state_d         = ENTRY_OPEN;
            end
            EXIT_STB: begin
                occ_d[car_id_q] = 1'b0;
                exit_clr        = 1'b1;
                timer_d         = '0;
                state_d         = EXIT_OPEN;
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                // A timeout leaves occupied alone: the core already counted the car.
                if (barrier_clear || (timer_q == TMR_LAST)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            car_id_q     <= '0;
            ticket_q     <= '0;
            timer_q      <= '0;
            entry_pend_q <= 1'b0;
            exit_pend_q  <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            car_id_q     <= car_id_d;
            ticket_q     <= ticket_d;
            timer_q      <= timer_d;
            entry_pend_q <= entry_pend_d;
            exit_pend_q  <= exit_pend_d;
            reject_q     <= reject_d;
        end
    end

    assign entry           = (state_q == ENTRY_STB);
    assign exit            = (state_q == EXIT_STB);
    assign entry_gate_open = (state_q == ENTRY_OPEN);
    assign exit_gate_open  = (state_q == EXIT_OPEN);
    assign Car_Id          = car_id_q;
    assign occupied        = occ_q;
    assign reject          = reject_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus randomized requests against a slot-set model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_parking_gate_ctrl;

    localparam int MAX_CARS        = 3;
    localparam int GATE_TIMEOUT    = 32;
    localparam int DEBOUNCE_CYCLES = 8;
`ifdef PARKING_GATE_DEBOUNCE_EN
    localparam int PULSE_H = DEBOUNCE_CYCLES + 3;
`else
    localparam int PULSE_H = 2;
`endif
    localparam int EV_ENTRY  = 0;
    localparam int EV_EXIT   = 1;
    localparam int EV_REJECT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor = 1'b0;
    logic [1:0] exit_ticket_id = 2'd0;
    logic       barrier_clear = 1'b0;
    logic       entry;
    logic       exit;
    logic [1:0] Car_Id;
    logic       entry_gate_open;
    logic       exit_gate_open;
    logic [3:0] occupied;
    logic       reject;

    int total = 0;
    int bad   = 0;

    parking_gate_ctrl #(
        .MAX_CARS        (MAX_CARS),
        .GATE_TIMEOUT    (GATE_TIMEOUT),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .entry_sensor    (entry_sensor),
        .exit_sensor     (exit_sensor),
        .exit_ticket_id  (exit_ticket_id),
        .barrier_clear   (barrier_clear),
        .entry           (entry),
        .exit            (exit),
        .Car_Id          (Car_Id),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .occupied        (occupied),
        .reject          (reject)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed event log and protocol bookkeeping, sampled on the falling edge.
    typedef struct {
        int         kind;
        logic [1:0] id;
    } ev_t;

    ev_t  ev_q[$];
    int   overlap_cnt   = 0;
    int   seq_err_cnt   = 0;
    int   gate_rise_cnt = 0;
    int   open_run      = 0;
    int   last_run      = 0;
    logic prev_gate     = 1'b0;
    logic prev_strobe   = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            open_run    = 0;
            prev_gate   = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            if (entry)  begin e.kind = EV_ENTRY;  e.id = Car_Id; ev_q.push_back(e); end
            if (exit)   begin e.kind = EV_EXIT;   e.id = Car_Id; ev_q.push_back(e); end
            if (reject) begin e.kind = EV_REJECT; e.id = Car_Id; ev_q.push_back(e); end
            if (entry && exit) overlap_cnt++;
            if (entry_gate_open && exit_gate_open) overlap_cnt++;
            if ((entry_gate_open || exit_gate_open) && !prev_gate) begin
                gate_rise_cnt++;
                if (!prev_strobe) seq_err_cnt++;
            end
            if (entry_gate_open || exit_gate_open) begin
                open_run++;
            end else if (open_run != 0) begin
                last_run = open_run;
                open_run = 0;
            end
            prev_gate   = entry_gate_open | exit_gate_open;
            prev_strobe = entry | exit;
        end
    end

    // Reference model: the set of IDs in use. An entry takes the smallest ID not
    // in the set unless MAX_CARS are already in; an exit must name a member.
    bit m_occ[4];

    function automatic int m_used();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(m_occ[i]);
        return n;
    endfunction

    function automatic logic [3:0] m_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic m_apply(input bit is_exit, input logic [1:0] t, output int kind, output logic [1:0] id);
        int slot;
        id = 2'd0;
        if (is_exit) begin
            if (m_occ[t]) begin
                m_occ[t] = 1'b0;
                kind = EV_EXIT;
                id = t;
            end else begin
                kind = EV_REJECT;
            end
        end else if (m_used() >= MAX_CARS) begin
            kind = EV_REJECT;
        end else begin
            slot = 0;
            while (m_occ[slot]) slot++;
            m_occ[slot] = 1'b1;
            kind = EV_ENTRY;
            id = 2'(slot);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m_occ[i] = 1'b0;
    endtask

    // Stimulus helpers; inputs change 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit on_exit);
        if (on_exit) exit_sensor = 1'b1; else entry_sensor = 1'b1;
        cyc(PULSE_H);
        if (on_exit) exit_sensor = 1'b0; else entry_sensor = 1'b0;
        cyc(PULSE_H);
    endtask

    // Issue one request and report the first resulting event (-1 if none arrives).
    task automatic do_op(input bit is_exit, input logic [1:0] t, input bit clear_it,
                         output int kind, output logic [1:0] id);
        int n0;
        n0 = ev_q.size();
        exit_ticket_id = t;
        pulse(is_exit);
        for (int k = 0; k < 80 && ev_q.size() == n0; k++) cyc(1);
        if (ev_q.size() == n0) begin
            kind = -1;
            id = 2'd0;
            return;
        end
        kind = ev_q[n0].kind;
        id   = ev_q[n0].id;
        if (kind != EV_REJECT) begin
            for (int k = 0; k < 12 && !(entry_gate_open || exit_gate_open); k++) cyc(1);
            if (clear_it) begin
                barrier_clear = 1'b1;
                cyc(1);
                barrier_clear = 1'b0;
            end
            for (int k = 0; k < 60 && (entry_gate_open || exit_gate_open); k++) cyc(1);
        end
        cyc(3);
    endtask

    // Clear gates as they open until `want` events are logged and the gates are shut.
    task automatic drain(input int want);
        for (int k = 0; k < 200; k++) begin
            if (entry_gate_open || exit_gate_open) begin
                barrier_clear = 1'b1;
                cyc(1);
                barrier_clear = 1'b0;
            end else if (ev_q.size() >= want) begin
                break;
            end else begin
                cyc(1);
            end
        end
        cyc(40);
    endtask

    task automatic test_reset();
        cyc(3);
        total++; if (entry !== 1'b0)           begin bad++; $display("FAIL rst_entry: got %b want 0", entry); end
        total++; if (exit !== 1'b0)            begin bad++; $display("FAIL rst_exit: got %b want 0", exit); end
        total++; if (Car_Id !== 2'd0)          begin bad++; $display("FAIL rst_car_id: got %0d want 0", Car_Id); end
        total++; if (entry_gate_open !== 1'b0) begin bad++; $display("FAIL rst_entry_gate: got %b want 0", entry_gate_open); end
        total++; if (exit_gate_open !== 1'b0)  begin bad++; $display("FAIL rst_exit_gate: got %b want 0", exit_gate_open); end
        total++; if (occupied !== 4'b0000)     begin bad++; $display("FAIL rst_occupied: got %b want 0000", occupied); end
        total++; if (reject !== 1'b0)          begin bad++; $display("FAIL rst_reject: got %b want 0", reject); end
        reset = 1'b0;
        cyc(3);
        // Reset while the entry barrier is open after the first car.
        pulse(1'b0);
        for (int k = 0; k < 40 && !entry_gate_open; k++) cyc(1);
        total++; if (entry_gate_open !== 1'b1) begin bad++; $display("FAIL mid_gate_open: got %b want 1", entry_gate_open); end
        total++; if (occupied !== 4'b0001)     begin bad++; $display("FAIL mid_occupied: got %b want 0001", occupied); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (entry_gate_open !== 1'b0) begin bad++; $display("FAIL mid_rst_gate: got %b want 0", entry_gate_open); end
        total++; if (occupied !== 4'b0000)     begin bad++; $display("FAIL mid_rst_occupied: got %b want 0000", occupied); end
        total++; if ({entry, exit, exit_gate_open, reject, Car_Id} !== 6'd0)
            begin bad++; $display("FAIL mid_rst_others: got %b want 000000", {entry, exit, exit_gate_open, reject, Car_Id}); end
        cyc(2);
        reset = 1'b0;
        m_clear();
        cyc(3);
    endtask

    task automatic test_fill();
        int ek, k;
        logic [1:0] eid, id;
        for (int i = 0; i < 3; i++) begin
            m_apply(1'b0, 2'd0, ek, eid);
            do_op(1'b0, 2'd0, 1'b1, k, id);
            total++; if (k !== EV_ENTRY) begin bad++; $display("FAIL fill_kind[%0d]: got %0d want %0d", i, k, EV_ENTRY); end
            total++; if (id !== 2'(i))   begin bad++; $display("FAIL fill_id[%0d]: got %0d want %0d", i, id, i); end
        end
        total++; if (occupied !== 4'b0111) begin bad++; $display("FAIL fill_occupied: got %b want 0111", occupied); end
    endtask

    task automatic test_full_reject();
        int ek, k, n0, r0;
        logic [1:0] eid, id;
        n0 = ev_q.size();
        r0 = gate_rise_cnt;
        m_apply(1'b0, 2'd0, ek, eid);
        do_op(1'b0, 2'd0, 1'b1, k, id);
        cyc(10);
        total++; if (k !== EV_REJECT)         begin bad++; $display("FAIL full_kind: got %0d want %0d", k, EV_REJECT); end
        total++; if (ev_q.size() !== n0 + 1)  begin bad++; $display("FAIL full_events: got %0d want %0d", ev_q.size() - n0, 1); end
        total++; if (gate_rise_cnt !== r0)    begin bad++; $display("FAIL full_gate_rises: got %0d want %0d", gate_rise_cnt, r0); end
        total++; if (occupied !== 4'b0111)    begin bad++; $display("FAIL full_occupied: got %b want 0111", occupied); end
    endtask

    task automatic test_exit();
        int ek, k;
        logic [1:0] eid, id;
        m_apply(1'b1, 2'd1, ek, eid);
        do_op(1'b1, 2'd1, 1'b1, k, id);
        total++; if (k !== EV_EXIT)        begin bad++; $display("FAIL exit1_kind: got %0d want %0d", k, EV_EXIT); end
        total++; if (id !== 2'd1)          begin bad++; $display("FAIL exit1_id: got %0d want 1", id); end
        total++; if (occupied !== 4'b0101) begin bad++; $display("FAIL exit1_occupied: got %b want 0101", occupied); end
        m_apply(1'b1, 2'd3, ek, eid);
        do_op(1'b1, 2'd3, 1'b1, k, id);
        total++; if (k !== EV_REJECT)      begin bad++; $display("FAIL exit3_kind: got %0d want %0d", k, EV_REJECT); end
        total++; if (occupied !== 4'b0101) begin bad++; $display("FAIL exit3_occupied: got %b want 0101", occupied); end
        total++; if (Car_Id !== 2'd1)      begin bad++; $display("FAIL exit3_car_id_held: got %0d want 1", Car_Id); end
        m_apply(1'b0, 2'd0, ek, eid);
        do_op(1'b0, 2'd0, 1'b1, k, id);
        total++; if (k !== EV_ENTRY)       begin bad++; $display("FAIL reuse_kind: got %0d want %0d", k, EV_ENTRY); end
        total++; if (id !== 2'd1)          begin bad++; $display("FAIL reuse_id: got %0d want 1", id); end
        total++; if (occupied !== 4'b0111) begin bad++; $display("FAIL reuse_occupied: got %b want 0111", occupied); end
    endtask

    task automatic test_simultaneous();
        int ek, k, n0;
        logic [1:0] eid, id;
        for (int t = 1; t <= 2; t++) begin
            m_apply(1'b1, 2'(t), ek, eid);
            do_op(1'b1, 2'(t), 1'b1, k, id);
        end
        total++; if (occupied !== 4'b0001) begin bad++; $display("FAIL sim_setup_occupied: got %b want 0001", occupied); end
        n0 = ev_q.size();
        exit_ticket_id = 2'd0;
        fork
            pulse(1'b1);
            pulse(1'b0);
        join
        drain(n0 + 2);
        m_apply(1'b1, 2'd0, ek, eid);
        m_apply(1'b0, 2'd0, ek, eid);
        total++; if (ev_q.size() !== n0 + 2) begin bad++; $display("FAIL sim_events: got %0d want 2", ev_q.size() - n0); end
        if (ev_q.size() >= n0 + 2) begin
            total++; if (ev_q[n0].kind !== EV_EXIT)    begin bad++; $display("FAIL sim_first_kind: got %0d want %0d", ev_q[n0].kind, EV_EXIT); end
            total++; if (ev_q[n0].id !== 2'd0)         begin bad++; $display("FAIL sim_first_id: got %0d want 0", ev_q[n0].id); end
            total++; if (ev_q[n0+1].kind !== EV_ENTRY) begin bad++; $display("FAIL sim_second_kind: got %0d want %0d", ev_q[n0+1].kind, EV_ENTRY); end
            total++; if (ev_q[n0+1].id !== 2'd0)       begin bad++; $display("FAIL sim_second_id: got %0d want 0", ev_q[n0+1].id); end
        end
        total++; if (overlap_cnt !== 0)          begin bad++; $display("FAIL sim_overlap: got %0d want 0", overlap_cnt); end
        total++; if (occupied !== m_vec())       begin bad++; $display("FAIL sim_occupied: got %b want %b", occupied, m_vec()); end
    endtask

    task automatic test_back_to_back();
        int ek, n0;
        logic [1:0] eid;
        n0 = ev_q.size();
        exit_ticket_id = 2'd0;
        // Two entry edges while the exit is being served: only one car may be admitted.
        fork
            pulse(1'b1);
            begin
                pulse(1'b0);
                pulse(1'b0);
            end
        join
        drain(n0 + 2);
        m_apply(1'b1, 2'd0, ek, eid);
        m_apply(1'b0, 2'd0, ek, eid);
        total++; if (ev_q.size() !== n0 + 2) begin bad++; $display("FAIL b2b_events: got %0d want 2", ev_q.size() - n0); end
        if (ev_q.size() >= n0 + 2) begin
            total++; if (ev_q[n0].kind !== EV_EXIT)    begin bad++; $display("FAIL b2b_first_kind: got %0d want %0d", ev_q[n0].kind, EV_EXIT); end
            total++; if (ev_q[n0+1].kind !== EV_ENTRY) begin bad++; $display("FAIL b2b_second_kind: got %0d want %0d", ev_q[n0+1].kind, EV_ENTRY); end
            total++; if (ev_q[n0+1].id !== eid)        begin bad++; $display("FAIL b2b_second_id: got %0d want %0d", ev_q[n0+1].id, eid); end
        end
        total++; if (occupied !== m_vec()) begin bad++; $display("FAIL b2b_occupied: got %b want %b", occupied, m_vec()); end
    endtask

    task automatic test_timeout();
        int ek, k;
        logic [1:0] eid, id;
        m_apply(1'b0, 2'd0, ek, eid);
        do_op(1'b0, 2'd0, 1'b0, k, id);
        total++; if (k !== ek)                   begin bad++; $display("FAIL tmo_kind: got %0d want %0d", k, ek); end
        total++; if (id !== eid)                 begin bad++; $display("FAIL tmo_id: got %0d want %0d", id, eid); end
        total++; if (last_run !== GATE_TIMEOUT)  begin bad++; $display("FAIL tmo_open_cycles: got %0d want %0d", last_run, GATE_TIMEOUT); end
        total++; if (occupied !== m_vec())       begin bad++; $display("FAIL tmo_occupied: got %b want %b", occupied, m_vec()); end
    endtask

`ifdef PARKING_GATE_DEBOUNCE_EN
    task automatic test_glitch();
        int n0;
        n0 = ev_q.size();
        entry_sensor = 1'b1;
        cyc(3);
        entry_sensor = 1'b0;
        cyc(40);
        total++; if (ev_q.size() !== n0) begin bad++; $display("FAIL glitch_events: got %0d want 0", ev_q.size() - n0); end
    endtask
`endif

    task automatic test_random();
        int ek, k;
        logic [1:0] eid, id, t;
        bit is_exit, clear_it;
        for (int i = 0; i < 40; i++) begin
            is_exit  = 1'($urandom_range(0, 1));
            t        = 2'($urandom_range(0, 3));
            clear_it = ($urandom_range(0, 3) != 0);
            m_apply(is_exit, t, ek, eid);
            do_op(is_exit, t, clear_it, k, id);
            total++; if (k !== ek) begin bad++; $display("FAIL rnd_kind[%0d]: got %0d want %0d", i, k, ek); end
            if (ek != EV_REJECT) begin
                total++; if (id !== eid) begin bad++; $display("FAIL rnd_id[%0d]: got %0d want %0d", i, id, eid); end
            end
            total++; if (occupied !== m_vec()) begin bad++; $display("FAIL rnd_occupied[%0d]: got %b want %b", i, occupied, m_vec()); end
        end
    endtask

    task automatic test_invariants();
        total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL inv_overlap: got %0d want 0", overlap_cnt); end
        total++; if (seq_err_cnt !== 0) begin bad++; $display("FAIL inv_gate_after_strobe: got %0d want 0", seq_err_cnt); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_reject();
        test_exit();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
`ifdef PARKING_GATE_DEBOUNCE_EN
        test_glitch();
`endif
        test_random();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Gate-side controller for the parking core: turns raw entry/exit sensor events into the core's `entry`/`exit` strobes and `Car_Id`. It allocates the lowest free slot ID on entry and validates the presented ticket ID on exit. It drives both barrier motors and rejects entries when the lot is full and exits with unknown IDs. It sits in front of the core on the same fast `clk` as the core's FSM/counter/buffer.

## Interface
Parameters:
- `MAX_CARS`, 3: occupancy limit; matches the core's 2-bit `cars_count`. Legal 1..4.
- `GATE_TIMEOUT`, 32: cycles a barrier stays open waiting for `barrier_clear`.
- `DEBOUNCE_CYCLES`, 8: stable cycles required per sensor level change. Used only with `PARKING_GATE_DEBOUNCE_EN`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `entry_sensor`  in  1  raw async car-present at entry.
- `exit_sensor`  in  1  raw async car-present at exit.
- `exit_ticket_id`  in  2  ID read from ticket; sampled on the exit request.
- `barrier_clear`  in  1  synchronous; car has passed the open barrier.
- `entry`  out  1  one-cycle strobe to core.
- `exit`  out  1  one-cycle strobe to core.
- `Car_Id`  out  2  ID for the current strobe; held until the next strobe.
- `entry_gate_open`  out  1  entry barrier drive.
- `exit_gate_open`  out  1  exit barrier drive.
- `occupied`  out  4  slot bitmap; bit i = ID i in use.
- `reject`  out  1  one-cycle strobe: full on entry, or unknown ID on exit.

## Operation
- Each sensor goes through a 2-flop synchroniser. The request is the rising edge of the synchronised (optionally debounced) level.
- Requests arriving in any state latch into `entry_pend`/`exit_pend`. Exit request also latches `exit_ticket_id`.
- FSM states: IDLE, ENTRY_STB, ENTRY_OPEN, EXIT_STB, EXIT_OPEN.
- **IDLE**, exit has priority over entry:
  - `exit_pend` and `occupied[id]` = 1 -> EXIT_STB.
  - `exit_pend` and `occupied[id]` = 0 -> `reject` pulse, clear `exit_pend`, stay in IDLE.
  - Else `entry_pend` and popcount(`occupied`) < `MAX_CARS` -> ENTRY_STB.
  - Else `entry_pend` and full -> `reject` pulse, clear `entry_pend`.
- **ENTRY_STB**, one cycle:
  - `entry`=1; `Car_Id` = lowest clear bit of `occupied` among IDs 0..3.
  - Set that bit; clear `entry_pend`; -> ENTRY_OPEN.
- **EXIT_STB**, one cycle:
  - `exit`=1; `Car_Id` = latched ticket ID.
  - Clear that bit and `exit_pend`; -> EXIT_OPEN.
- **ENTRY_OPEN / EXIT_OPEN**:
  - The matching gate output is 1; timer counts from 0.
  - `barrier_clear`, or timer = `GATE_TIMEOUT`-1 -> gate closes, -> IDLE.
  - Timeout does not roll back `occupied`; the core has already counted the car.
- `entry` and `exit` are never high in the same cycle. At most one gate is open.
- A new request during STB/OPEN stays pending and is served from IDLE. A second edge on the same sensor while its pend is already set is absorbed (no double count).
- Reset: asynchronous. Clears FSM to IDLE, `occupied`, pends, timer and synchronisers. All outputs go to 0.

## Timing
- Reset values of every output are 0: `entry`, `exit`, `Car_Id`, both gates, `occupied`, `reject`.
- Sensor edge to pend set: 3 cycles without the macro. With the macro, add `DEBOUNCE_CYCLES`.
- Pend set in IDLE to strobe: 2 cycles (IDLE decision, then STB).
- `occupied` updates on the clock edge ending the STB cycle.
- Gate output rises the cycle after the strobe and falls the cycle after `barrier_clear`.
- A reject decision takes 1 cycle in IDLE, with no state change.

## Configuration
- `PARKING_GATE_DEBOUNCE_EN` defined:
  - Each synchronised sensor feeds a debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive cycles at the new value.
  - Glitches shorter than that produce no request.
- Not defined: the synchronised level is used directly, and every clean rising edge is a request.

## Structure
- Shared package `parking_pkg`:
  - FSM state enum.
  - `CAR_ID_W`=2 and `NUM_SLOTS`=4.
  - Lowest-free-slot priority-encoder function.
  - Popcount function.
- One sub-module: `sensor_debounce`, instantiated twice. It contains the 2-flop sync, the macro-gated debounce and rising-edge detect.

## Test plan
- Reset mid-ENTRY_OPEN (gate=1, `occupied`=0001) -> all outputs 0 immediately, FSM back in IDLE.
- Three entry edges, each followed by `barrier_clear` -> `entry` strobes with `Car_Id` 0, 1, 2; `occupied`=0111.
- Fourth entry edge with `occupied`=0111 -> `reject` pulse, no `entry` strobe, `entry_gate_open` stays 0.
- Exit with ticket 1 from 0111 -> `exit` strobe with `Car_Id`=1, `occupied`=0101. The next entry then gets `Car_Id`=1.
- Exit with ticket 3 from 0101 -> `reject` pulse, `occupied` unchanged.
- Entry and exit edges in the same cycle with `occupied`=0001 and ticket 0:
  - Exit strobe first, ID 0.
  - After `barrier_clear`, entry strobe with ID 0.
  - No gate is ever open concurrently with the other.
  - `GATE_TIMEOUT`=32 with no `barrier_clear` -> gate falls exactly 32 cycles after opening.
  - With the macro: a 3-cycle sensor glitch gives no request.
